// File: rtl/w_bank_streamer.sv
// rtl/w_bank_streamer.sv - per-neuron weight/bias store streamed LANES weights per beat
// Optional runtime write port: define WSTREAM_WRITE_EN.
module w_bank_streamer #(
    parameter int    DATA_WIDTH  = 16,
    parameter int    FRAC_BITS   = 10,
    parameter int    FAN_IN      = 16,
    parameter int    NUM_NEURONS = 8,
    parameter int    LANES       = 4,
    parameter string INIT_FILE   = "",
    localparam int   IDXW  = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1,
    localparam int   BEATS = FAN_IN / LANES + 1,
    localparam int   DEPTH = NUM_NEURONS * BEATS,
    localparam int   AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int   BW    = $clog2(BEATS),
    localparam int   WW    = LANES * DATA_WIDTH
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_valid_i,
    output logic            start_ready_o,
    input  logic [IDXW-1:0] start_idx_i,
`ifdef WSTREAM_WRITE_EN
    input  logic            wr_en_i,
    input  logic [AW-1:0]   wr_addr_i,
    input  logic [WW-1:0]   wr_data_i,
`endif
    output logic            w_valid_o,
    input  logic            w_ready_i,
    output logic [WW-1:0]   w_data_o,
    output logic            w_is_bias_o,
    output logic            w_last_o,
    output logic            busy_o,
    output logic            err_idx_o
);

    if (FAN_IN % LANES != 0 || NUM_NEURONS < 1 || FRAC_BITS >= DATA_WIDTH) begin : g_bad_cfg
        $error("w_bank_streamer: illegal parameter set");
    end

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_STREAM} state_t;

    state_t          state_q, state_d;
    logic [WW-1:0]   mem_q [DEPTH];
    logic [AW-1:0]   base_q;
    logic [BW-1:0]   beat_q;
    logic            w_valid_q;
    logic [WW-1:0]   w_data_q;
    logic            w_is_bias_q;
    logic            err_q;

    logic            start_fire;
    logic            idx_ok;
    logic            last_beat;
    logic            load;
    logic            load_bias;
    logic            drain;
    logic [AW-1:0]   rd_addr;

    // Memory is preloaded only; reset never clears it.
    initial begin
        for (int i = 0; i < DEPTH; i++) mem_q[i] = '0;
    end

    assign start_fire = start_valid_i && (state_q == S_IDLE);
    assign idx_ok     = 32'(start_idx_i) < NUM_NEURONS;
    assign last_beat  = (beat_q == BW'(BEATS - 1));

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start_fire && idx_ok) state_d = S_FETCH;
            S_FETCH:  state_d = S_STREAM;
            S_STREAM: if (w_ready_i && last_beat) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // The output register doubles as the read register: the next word is
    // fetched on the same edge the current beat transfers, so there are no bubbles.
    always_comb begin
        start_ready_o = (state_q == S_IDLE);
        busy_o        = (state_q != S_IDLE);
        load          = 1'b0;
        load_bias     = 1'b0;
        drain         = 1'b0;
        rd_addr       = base_q;
        case (state_q)
            S_FETCH: load = 1'b1;
            S_STREAM: begin
                rd_addr   = base_q + AW'(beat_q) + AW'(1);
                load      = w_ready_i && !last_beat;
                load_bias = (beat_q == BW'(BEATS - 2));
                drain     = w_ready_i && last_beat;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            base_q      <= '0;
            beat_q      <= '0;
            w_valid_q   <= 1'b0;
            w_data_q    <= '0;
            w_is_bias_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            if (start_fire && !idx_ok) err_q <= 1'b1;
            if (start_fire) begin
                base_q <= AW'(start_idx_i) * AW'(BEATS);
                beat_q <= '0;
            end
            if (load) begin
                w_data_q    <= mem_q[rd_addr];
                w_is_bias_q <= load_bias;
                w_valid_q   <= 1'b1;
                if (state_q == S_STREAM) beat_q <= beat_q + BW'(1);
            end else if (drain) begin
                w_valid_q   <= 1'b0;
                w_is_bias_q <= 1'b0;
            end
        end
    end

`ifdef WSTREAM_WRITE_EN
    always_ff @(posedge clk_i) begin
        if (wr_en_i && (state_q == S_IDLE) && !start_fire) mem_q[wr_addr_i] <= wr_data_i;
    end
`endif

    assign w_valid_o   = w_valid_q;
    assign w_data_o    = w_data_q;
    assign w_is_bias_o = w_is_bias_q;
    assign w_last_o    = w_is_bias_q;
    assign err_idx_o   = err_q;

endmodule

// File: tb/tb_w_bank_streamer.sv
// tb/tb_w_bank_streamer.sv - scoreboard bench for w_bank_streamer
module tb_w_bank_streamer;
    localparam int DW = 16, LN = 4, FI = 16, NN = 6, B = FI / LN + 1, W = LN * DW;
    localparam int IDXW = 3, AW = 5;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start_valid = 1'b0;
    logic            start_ready;
    logic [IDXW-1:0] start_idx = '0;
    logic            w_valid;
    logic            w_ready = 1'b0;
    logic [W-1:0]    w_data;
    logic            w_is_bias, w_last, busy, err_idx;
`ifdef WSTREAM_WRITE_EN
    logic            wr_en = 1'b0;
    logic [AW-1:0]   wr_addr = '0;
    logic [W-1:0]    wr_data = '0;
`endif

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] wts [NN][FI];
    logic [DW-1:0] bias [NN];

    typedef struct packed {
        logic [W-1:0] data;
        logic         bias;
    } beat_t;
    beat_t sb [$];

    w_bank_streamer #(.NUM_NEURONS(NN)) dut (
        .clk_i(clk), .rst_i(rst),
        .start_valid_i(start_valid), .start_ready_o(start_ready), .start_idx_i(start_idx),
`ifdef WSTREAM_WRITE_EN
        .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
`endif
        .w_valid_o(w_valid), .w_ready_i(w_ready), .w_data_o(w_data),
        .w_is_bias_o(w_is_bias), .w_last_o(w_last), .busy_o(busy), .err_idx_o(err_idx)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] exp_word(input int n, input int b);
        logic [W-1:0] w;
        w = '0;
        if (b == B - 1) w[DW-1:0] = bias[n];
        else for (int k = 0; k < LN; k++) w[k*DW +: DW] = wts[n][b*LN + k];
        return w;
    endfunction

    task automatic preload();
        for (int n = 0; n < NN; n++) begin
            for (int i = 0; i < FI; i++) wts[n][i] = DW'($urandom);
            bias[n] = DW'($urandom);
        end
        wts[0][0] = 16'hffd7; wts[0][1] = 16'h0082; wts[0][2] = 16'h0166; wts[0][3] = 16'h004d;
        bias[0] = 16'hfe4d;
        for (int n = 0; n < NN; n++) begin
            for (int b = 0; b < B; b++) begin
`ifdef WSTREAM_WRITE_EN
                wr_en = 1'b1; wr_addr = AW'(n*B + b); wr_data = exp_word(n, b);
                step();
`else
                dut.mem_q[n*B + b] = exp_word(n, b);
`endif
            end
        end
`ifdef WSTREAM_WRITE_EN
        wr_en = 1'b0;
`endif
    endtask

    // Starts neuron idx, consumes its stream and checks it against the scoreboard.
    // mode 0: w_ready held high; mode 1: w_ready 1,0,0 repeating per valid cycle.
    task automatic run_neuron(input int idx, input int mode);
        int c, k, got, vcnt, first;
        bit stall;
        logic [W-1:0] pd;
        logic pb;
        beat_t e;
        start_idx = IDXW'(idx);
        start_valid = 1'b1;
        c = 0;
        while (!start_ready && c < 100) begin step(); c++; end
        checks++;
        if (!start_ready) begin
            errors++; $display("FAIL start_ready_timeout n%0d: start_ready=%b required 1", idx, start_ready);
        end
        for (int b = 0; b < B; b++) sb.push_back('{data: exp_word(idx, b), bias: (b == B - 1)});
        step();
        start_valid = 1'b0;
        c = 1; k = 0; got = 0; vcnt = 0; first = 0; stall = 0; pd = '0; pb = 1'b0;
        while (got < B && c < 200) begin
            w_ready = (mode == 0) ? 1'b1 : (k % 3 == 0);
            if (w_valid) begin
                if (first == 0) first = c;
                vcnt++;
                if (stall) begin
                    checks++;
                    if (w_data !== pd || w_is_bias !== pb) begin
                        errors++;
                        $display("FAIL hold n%0d: data=%h bias=%b required data=%h bias=%b", idx, w_data, w_is_bias, pd, pb);
                    end
                end
                if (w_ready) begin
                    checks++;
                    if (sb.size() == 0) begin
                        errors++; $display("FAIL extra_beat n%0d: data=%h required no beat", idx, w_data);
                    end else begin
                        e = sb.pop_front();
                        if (w_data !== e.data || w_is_bias !== e.bias || w_last !== e.bias) begin
                            errors++;
                            $display("FAIL beat n%0d b%0d: data=%h bias=%b last=%b required data=%h bias=%b last=%b",
                                     idx, got, w_data, w_is_bias, w_last, e.data, e.bias, e.bias);
                        end
                    end
                    got++;
                end
                stall = !w_ready; pd = w_data; pb = w_is_bias; k++;
            end else if (stall) begin
                checks++; errors++;
                $display("FAIL valid_drop n%0d: w_valid=0 required 1", idx);
                stall = 0;
            end
            step();
            c++;
        end
        w_ready = 1'b1;
        checks++;
        if (got != B) begin
            errors++; $display("FAIL beat_count n%0d: beats=%0d required %0d", idx, got, B);
        end
        checks++;
        if (first != 2) begin
            errors++; $display("FAIL latency n%0d: first valid at T+%0d required T+2", idx, first);
        end
        if (mode == 0) begin
            checks++;
            if (vcnt != B) begin
                errors++; $display("FAIL valid_cycles n%0d: %0d required %0d", idx, vcnt, B);
            end
        end
        checks++;
        if (w_valid !== 1'b0 || start_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL after_stream n%0d: valid=%b ready=%b busy=%b required 0 1 0", idx, w_valid, start_ready, busy);
        end
        sb.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        checks++; if (w_valid !== 1'b0)  begin errors++; $display("FAIL rst_w_valid: %b required 0", w_valid); end
        checks++; if (w_data !== '0)     begin errors++; $display("FAIL rst_w_data: %h required 0", w_data); end
        checks++; if (w_is_bias !== 1'b0) begin errors++; $display("FAIL rst_w_is_bias: %b required 0", w_is_bias); end
        checks++; if (w_last !== 1'b0)   begin errors++; $display("FAIL rst_w_last: %b required 0", w_last); end
        checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL rst_busy: %b required 0", busy); end
        checks++; if (err_idx !== 1'b0)  begin errors++; $display("FAIL rst_err_idx: %b required 0", err_idx); end
        checks++; if (start_ready !== 1'b1) begin errors++; $display("FAIL rst_start_ready: %b required 1", start_ready); end
    endtask

    task automatic test_basic();
        start_idx = '0; start_valid = 1'b1; w_ready = 1'b1;
        step();
        start_valid = 1'b0;
        checks++;
        if (w_valid !== 1'b0 || busy !== 1'b1 || start_ready !== 1'b0) begin
            errors++; $display("FAIL basic_fetch: valid=%b busy=%b ready=%b required 0 1 0", w_valid, busy, start_ready);
        end
        step();
        for (int b = 0; b < B; b++) begin
            checks++;
            if (w_valid !== 1'b1) begin errors++; $display("FAIL basic_valid b%0d: %b required 1", b, w_valid); end
            if (b == 0) begin
                checks++;
                if (w_data !== 64'h004d_0166_0082_ffd7 || w_is_bias !== 1'b0) begin
                    errors++; $display("FAIL basic_first: data=%h bias=%b required 004d01660082ffd7 0", w_data, w_is_bias);
                end
            end
            if (b == B - 1) begin
                checks++;
                if (w_data !== 64'h0000_0000_0000_fe4d || w_last !== 1'b1 || w_is_bias !== 1'b1) begin
                    errors++; $display("FAIL basic_bias: data=%h last=%b required 000000000000fe4d 1", w_data, w_last);
                end
            end
            step();
        end
        checks++;
        if (w_valid !== 1'b0 || start_ready !== 1'b1) begin
            errors++; $display("FAIL basic_end: valid=%b ready=%b required 0 1", w_valid, start_ready);
        end
        run_neuron(0, 0);
    endtask

    task automatic test_backpressure();
        run_neuron(3, 1);
    endtask

    task automatic test_bad_index();
        int seen;
        start_idx = 3'd7; start_valid = 1'b1;
        step();
        start_valid = 1'b0;
        checks++;
        if (err_idx !== 1'b1 || busy !== 1'b0 || start_ready !== 1'b1) begin
            errors++; $display("FAIL bad_idx: err=%b busy=%b ready=%b required 1 0 1", err_idx, busy, start_ready);
        end
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            if (w_valid) seen++;
            step();
        end
        checks++;
        if (seen != 0) begin errors++; $display("FAIL bad_idx_valid: %0d valid cycles required 0", seen); end
        run_neuron(2, 0);
        checks++;
        if (err_idx !== 1'b1) begin errors++; $display("FAIL err_sticky: %b required 1", err_idx); end
    endtask

    task automatic test_reset_mid();
        int got, c;
        start_idx = 3'd4; start_valid = 1'b1; w_ready = 1'b1;
        step();
        start_valid = 1'b0;
        got = 0; c = 0;
        while (got < 2 && c < 20) begin
            if (w_valid && w_ready) got++;
            step(); c++;
        end
        checks++;
        if (got != 2) begin errors++; $display("FAIL mid_beats: %0d required 2", got); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (w_valid !== 1'b0 || busy !== 1'b0 || start_ready !== 1'b1 || err_idx !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: valid=%b busy=%b ready=%b err=%b required 0 0 1 0", w_valid, busy, start_ready, err_idx);
        end
        run_neuron(1, 0);
    endtask

    task automatic test_back_to_back();
        run_neuron(5, 0);
        run_neuron(5, 1);
        run_neuron(0, 0);
    endtask

`ifdef WSTREAM_WRITE_EN
    task automatic test_write();
        wr_en = 1'b1; wr_addr = AW'(B - 1); wr_data = 64'h0000_0000_0000_0100;
        step();
        wr_en = 1'b0;
        bias[0] = 16'h0100;
        run_neuron(0, 0);
        wr_en = 1'b1; wr_addr = AW'(B - 1); wr_data = 64'h0000_0000_0000_7777;
        run_neuron(0, 1);
        wr_en = 1'b0;
        run_neuron(0, 0);
    endtask
`endif

    initial begin
        test_reset();
        preload();
        test_basic();
        test_backpressure();
        test_bad_index();
        test_reset_mid();
        test_back_to_back();
`ifdef WSTREAM_WRITE_EN
        test_write();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
